// File: rtl/tx_pkg_pkg.sv
// ---------------------------------------------------------------------------
// tx_pkg_pkg
// Shared definitions for the slave-side 485 packet transmitter:
//   - tx_state_t    : frame sequencer states
//   - SYNC_WORD_DEF : default frame sync word
//   - BITS_PER_WORD : start + 16 data + stop bit times per line word
//   - LEN_W / ID_W  : header field widths ({len, mod_id})
//   - make_header() : packs the header word
// Build option: TX_PKG_CHKSUM_EN adds the CHK state (checksum word).
// ---------------------------------------------------------------------------
package tx_pkg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GUARD_H,
    ST_SYNC,
    ST_HEAD,
    ST_DATA,
`ifdef TX_PKG_CHKSUM_EN
    ST_CHK,
`endif
    ST_GUARD_T
  } tx_state_t;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;
  localparam int BITS_PER_WORD = 18;
  localparam int LEN_W = 10;
  localparam int ID_W  = 6;

  // Header word: packet length in the upper bits, module id in the lower bits
  function automatic logic [15:0] make_header(input logic [LEN_W-1:0] len,
                                              input logic [ID_W-1:0]  id);
    return {len, id};
  endfunction

endpackage

// File: rtl/tx_pkg_ser.sv
// ---------------------------------------------------------------------------
// tx_pkg_ser
// Word serializer: bit timer plus 18-bit shift register. A load strobe
// captures {stop=1, word, start=0}; bits leave LSB first, each held for
// BIT_DIV clocks. done is high on the last clock of the stop bit so the
// next word can be loaded in the same cycle without a gap. The line idles
// at 1 whenever no word is in flight.
// Ports:
//   clk_sys, rst : clock, asynchronous active-high reset
//   load, word   : start serializing word
//   line         : registered serial line level
//   done         : last clock of the stop bit
// ---------------------------------------------------------------------------
module tx_pkg_ser
  import tx_pkg_pkg::*;
#(
  parameter int BIT_DIV = 20
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] word,
  output logic        line,
  output logic        done
);

  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [4:0]    BIT_LAST = 5'(BITS_PER_WORD - 1);

  logic [17:0]   sr;
  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic          active;

  assign line = sr[0];
  assign done = active && (div_cnt == DIV_LAST) && (bit_cnt == BIT_LAST);

  // Shift register and bit timer. A load always wins, which is what lets
  // the sequencer chain words back to back on the done cycle. Ones are
  // shifted in so the line returns to idle after the stop bit.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sr      <= '1;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
    end else if (load) begin
      sr      <= {1'b1, word, 1'b0};
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        sr      <= {1'b1, sr[17:1]};
        if (bit_cnt == BIT_LAST) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
    end
  end

endmodule

// File: rtl/tx_pkg_s.sv
// ---------------------------------------------------------------------------
// tx_pkg_s
// Slave-side 485 packet transmitter. Buffers one packet from the local
// acquisition stream and, on the master's fire_sync slot, drives the line
// with: head guard, SYNC_WORD, header {len, mod_id}, data words,
// [checksum], tail guard.
// Build option: define TX_PKG_CHKSUM_EN to append the checksum word
// (mod-2^16 sum of header and data words).
// Ports:
//   clk_sys, rst        : clock, asynchronous active-high reset
//   pkg_data/vld/frm    : packet word stream (vld qualified by frm)
//   mod_id              : module id placed in the header
//   fire_sync           : one-cycle send slot pulse
//   tx_a, tx_b          : differential serial line (tx_b = ~tx_a)
//   tx_ctrl             : 485 driver enable
//   busy                : packet ready or frame in progress
//   err_ovf             : one-cycle pulse on a dropped word/packet
// ---------------------------------------------------------------------------
module tx_pkg_s
  import tx_pkg_pkg::*;
#(
  parameter int          AW        = 8,
  parameter int          BIT_DIV   = 20,
  parameter int          GUARD     = 4,
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] pkg_data,
  input  logic        pkg_vld,
  input  logic        pkg_frm,
  input  logic [5:0]  mod_id,
  input  logic        fire_sync,
  output logic        tx_a,
  output logic        tx_b,
  output logic        tx_ctrl,
  output logic        busy,
  output logic        err_ovf
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [15:0] GB_LAST = 16'(GUARD * BIT_DIV - 1);

  tx_state_t   state;
  logic [15:0] mem [DEPTH];
  logic [15:0] rd_data;
  logic [AW:0] wcnt, len, widx;
  logic        ready, frm_q, discard;
  logic [15:0] gcnt;
  logic        vld_in, tx_active, wr_en, guard_last, frame_end;
  logic        ser_load, ser_done, ser_line;
  logic [15:0] ser_word, header_word;
`ifdef TX_PKG_CHKSUM_EN
  logic [15:0] chk_sum;
`endif

  assign vld_in      = pkg_vld & pkg_frm;
  assign tx_active   = ready | (state != ST_IDLE);
  assign wr_en       = vld_in & ~discard & ~tx_active & (wcnt != DEPTH_W);
  assign guard_last  = (gcnt == GB_LAST);
  assign frame_end   = (state == ST_GUARD_T) && guard_last;
  assign header_word = make_header(LEN_W'(len), mod_id);

  assign tx_a = ser_line;
  assign tx_b = ~ser_line;

  // Packet buffer: simple dual-port RAM. The read port follows widx every
  // cycle, so the next data word is already waiting when the serializer
  // reaches the stop bit of the current one.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wcnt[AW-1:0]] <= pkg_data;
    rd_data <= mem[widx[AW-1:0]];
  end

  // Capture side. A packet whose first word shows up while a packet is held
  // or a frame is on the line is dropped whole; discard stays set until its
  // frm falls so the rest of it is ignored without further error pulses.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wcnt    <= '0;
      len     <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      frm_q   <= 1'b0;
      discard <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      frm_q   <= pkg_frm;
      err_ovf <= 1'b0;
      if (frame_end) begin
        ready <= 1'b0;
        busy  <= 1'b0;
        wcnt  <= '0;
      end
      if (vld_in && !discard) begin
        if (tx_active) begin
          discard <= 1'b1;
          err_ovf <= 1'b1;
        end else if (wcnt == DEPTH_W) begin
          err_ovf <= 1'b1;
        end else begin
          wcnt <= wcnt + CNT_ONE;
        end
      end
      if (frm_q && !pkg_frm) begin
        discard <= 1'b0;
        if (!discard && !tx_active && (wcnt != '0)) begin
          ready <= 1'b1;
          busy  <= 1'b1;
          len   <= wcnt;
        end
      end
    end
  end

  // Word selection for the serializer; loads happen on the done cycle of
  // the previous word (or the last head-guard clock for the sync word).
  always_comb begin
    ser_load = 1'b0;
    ser_word = 16'h0000;
    case (state)
      ST_GUARD_H: if (guard_last) begin ser_load = 1'b1; ser_word = SYNC_WORD; end
      ST_SYNC:    if (ser_done) begin ser_load = 1'b1; ser_word = header_word; end
      ST_HEAD:    if (ser_done) begin ser_load = 1'b1; ser_word = rd_data; end
      ST_DATA: begin
        if (ser_done && (widx != len)) begin
          ser_load = 1'b1;
          ser_word = rd_data;
        end
`ifdef TX_PKG_CHKSUM_EN
        else if (ser_done) begin
          ser_load = 1'b1;
          ser_word = chk_sum;
        end
`endif
      end
      default: ;
    endcase
  end

`ifdef TX_PKG_CHKSUM_EN
  // Running checksum: seeded with the header, then every data word loaded.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      chk_sum <= '0;
    end else if (ser_load && (state == ST_SYNC)) begin
      chk_sum <= header_word;
    end else if (ser_load && ((state == ST_HEAD) ||
                              ((state == ST_DATA) && (widx != len)))) begin
      chk_sum <= chk_sum + ser_word;
    end
  end
`endif

  // Frame sequencer. widx counts data words already handed to the
  // serializer; the frame's data phase ends when it reaches len.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      gcnt    <= '0;
      widx    <= '0;
      tx_ctrl <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fire_sync && ready) begin
            state   <= ST_GUARD_H;
            gcnt    <= '0;
            widx    <= '0;
            tx_ctrl <= 1'b1;
          end
        end
        ST_GUARD_H: begin
          if (guard_last) state <= ST_SYNC;
          else            gcnt  <= gcnt + 16'd1;
        end
        ST_SYNC: if (ser_done) state <= ST_HEAD;
        ST_HEAD: begin
          if (ser_done) begin
            state <= ST_DATA;
            widx  <= CNT_ONE;
          end
        end
        ST_DATA: begin
          if (ser_done) begin
            if (widx != len) begin
              widx <= widx + CNT_ONE;
            end else begin
`ifdef TX_PKG_CHKSUM_EN
              state <= ST_CHK;
`else
              state <= ST_GUARD_T;
              gcnt  <= '0;
`endif
            end
          end
        end
`ifdef TX_PKG_CHKSUM_EN
        ST_CHK: begin
          if (ser_done) begin
            state <= ST_GUARD_T;
            gcnt  <= '0;
          end
        end
`endif
        ST_GUARD_T: begin
          if (guard_last) begin
            state   <= ST_IDLE;
            tx_ctrl <= 1'b0;
          end else begin
            gcnt <= gcnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  tx_pkg_ser #(.BIT_DIV(BIT_DIV)) u_ser (
    .clk_sys (clk_sys),
    .rst     (rst),
    .load    (ser_load),
    .word    (ser_word),
    .line    (ser_line),
    .done    (ser_done)
  );

endmodule

// File: tb/tb_tx_pkg_s.sv
// ---------------------------------------------------------------------------
// tb_tx_pkg_s
// Self-checking bench for tx_pkg_s (AW=8, BIT_DIV=4, GUARD=2). A frame-level
// reference model predicts the line waveform, driver enable, busy and
// err_ovf every clock; a line decoder recovers the words for literal checks.
// Honors TX_PKG_CHKSUM_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_tx_pkg_s;

  localparam int AW    = 8;
  localparam int BD    = 4;
  localparam int GD    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int GB    = GD * BD;
`ifdef TX_PKG_CHKSUM_EN
  localparam int C = 1;
`else
  localparam int C = 0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pkg_data = 16'h0;
  logic        pkg_vld = 1'b0;
  logic        pkg_frm = 1'b0;
  logic [5:0]  mod_id = 6'h05;
  logic        fire_sync = 1'b0;
  logic        tx_a, tx_b, tx_ctrl, busy, err_ovf;

  tx_pkg_s #(.AW(AW), .BIT_DIV(BD), .GUARD(GD)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .pkg_data  (pkg_data),
    .pkg_vld   (pkg_vld),
    .pkg_frm   (pkg_frm),
    .mod_id    (mod_id),
    .fire_sync (fire_sync),
    .tx_a      (tx_a),
    .tx_b      (tx_b),
    .tx_ctrl   (tx_ctrl),
    .busy      (busy),
    .err_ovf   (err_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: one held packet, one frame expanded to per-clock line levels
  int   m_words[$];
  int   m_frame_words[$];
  bit   m_bits[$];
  bit   m_ready = 0, m_discard = 0, m_frm_prev = 0, m_err = 0;
  int   m_pos = -1;

  function automatic void build_frame(input int id);
    int wl[$];
    int hdr, sum;
    hdr = ((m_words.size() % 1024) << 6) | id;
    wl.push_back(16'hEB90);
    wl.push_back(hdr);
    sum = hdr;
    foreach (m_words[i]) begin
      wl.push_back(m_words[i]);
      sum += m_words[i];
    end
    if (C == 1) wl.push_back(sum & 16'hFFFF);
    m_bits.delete();
    repeat (GB) m_bits.push_back(1'b1);
    foreach (wl[i]) begin
      repeat (BD) m_bits.push_back(1'b0);
      for (int b = 0; b < 16; b++) repeat (BD) m_bits.push_back(1'((wl[i] >> b) & 1));
      repeat (BD) m_bits.push_back(1'b1);
    end
    repeat (GB) m_bits.push_back(1'b1);
    m_frame_words = wl;
  endfunction

  always @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      m_words.delete();
      m_ready = 0; m_discard = 0; m_frm_prev = 0; m_err = 0; m_pos = -1;
    end else begin
      bit act, rdy0;
      int pos0;
      act  = m_ready || (m_pos >= 0);
      rdy0 = m_ready;
      pos0 = m_pos;
      m_err = 0;
      if (pkg_vld && pkg_frm && !m_discard) begin
        if (act) begin m_discard = 1; m_err = 1; end
        else if (m_words.size() == DEPTH) m_err = 1;
        else m_words.push_back(int'(pkg_data));
      end
      if (m_frm_prev && !pkg_frm) begin
        if (!m_discard && !act && m_words.size() > 0) m_ready = 1;
        m_discard = 0;
      end
      m_frm_prev = pkg_frm;
      if (pos0 >= 0) begin
        m_pos++;
        if (m_pos == m_bits.size()) begin
          m_pos = -1; m_ready = 0; m_words.delete();
        end
      end else if (fire_sync && rdy0) begin
        build_frame(int'(mod_id));
        m_pos = 0;
      end
    end
  end

  // Per-clock comparison against the model, away from the active edge
  always @(negedge clk_sys) begin
    bit el;
    el = (m_pos >= 0) ? m_bits[m_pos] : 1'b1;
    checkOutput("tx_a", 32'(tx_a), 32'(el));
    checkOutput("tx_b", 32'(tx_b), 32'(!el));
    checkOutput("tx_ctrl", 32'(tx_ctrl), 32'(m_pos >= 0));
    checkOutput("busy", 32'(busy), 32'(m_ready));
    checkOutput("err_ovf", 32'(err_ovf), 32'(m_err));
  end

  // Line decoder and activity counters
  logic [15:0] dec_q[$];
  int          rx_cnt = -1;
  logic [15:0] rx_sh = 16'h0;
  int          ctrl_cnt = 0;
  int          err_cnt = 0;

  always @(negedge clk_sys) begin
    if (tx_ctrl === 1'b1) ctrl_cnt++;
    if (err_ovf === 1'b1) err_cnt++;
    if (rst) begin
      rx_cnt = -1;
    end else if (rx_cnt < 0) begin
      if (tx_ctrl === 1'b1 && tx_a === 1'b0) rx_cnt = 0;
    end else begin
      rx_cnt++;
      if (rx_cnt % BD == BD / 2) begin
        int j;
        j = rx_cnt / BD;
        if (j >= 1 && j <= 16) rx_sh[j-1] = tx_a;
        else if (j == 17) begin
          dec_q.push_back(rx_sh);
          rx_cnt = -1;
        end
      end
    end
  end

  function automatic logic [31:0] dec_at(input int idx);
    if (idx < dec_q.size()) return 32'(dec_q[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  int stim_q[$];

  task automatic applyStimulus();
    @(posedge clk_sys); #2;
    pkg_frm = 1'b1;
    pkg_vld = 1'b0;
    foreach (stim_q[i]) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_sys); #2;
        pkg_vld  = 1'b0;
        pkg_data = 16'($urandom);
      end
      @(posedge clk_sys); #2;
      pkg_vld  = 1'b1;
      pkg_data = 16'(stim_q[i]);
    end
    @(posedge clk_sys); #2;
    pkg_frm  = 1'b0;
    pkg_vld  = 1'($urandom_range(0, 1));
    pkg_data = 16'($urandom);
    @(posedge clk_sys); #2;
    pkg_vld = 1'b0;
  endtask

  task automatic pulse_fire();
    @(posedge clk_sys); #2;
    fire_sync = 1'b1;
    @(posedge clk_sys); #2;
    fire_sync = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((busy !== 1'b0 || tx_ctrl !== 1'b0) && t < budget) begin
      @(negedge clk_sys);
      t++;
    end
    checkOutput("wait_idle_timeout", 32'(t >= budget), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, d0, e0;
    int lit3[$];
    int lit2[$];
    int litA[$];

    // Reset values
    repeat (2) @(negedge clk_sys);
    checkOutput("rst_tx_a", 32'(tx_a), 32'd1);
    checkOutput("rst_tx_b", 32'(tx_b), 32'd0);
    checkOutput("rst_tx_ctrl", 32'(tx_ctrl), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err_ovf", 32'(err_ovf), 32'd0);
    @(posedge clk_sys); #2;
    rst = 1'b0;

    // fire_sync with nothing buffered, then an empty frm pulse
    c0 = ctrl_cnt;
    pulse_fire();
    repeat (20) @(negedge clk_sys);
    checkOutput("nopkt_ctrl", 32'(ctrl_cnt - c0), 32'd0);
    @(posedge clk_sys); #2; pkg_frm = 1'b1;
    repeat (3) @(posedge clk_sys);
    #2; pkg_frm = 1'b0;
    repeat (3) @(posedge clk_sys);
    pulse_fire();
    repeat (20) @(negedge clk_sys);
    checkOutput("empty_ctrl", 32'(ctrl_cnt - c0), 32'd0);
    checkOutput("empty_busy", 32'(busy), 32'd0);

    // Reference packet with hand-computed line content
    mod_id = 6'h05;
    stim_q = '{16'h1234, 16'h5678, 16'h9ABC};
    lit3 = '{16'hEB90, 16'h00C5, 16'h1234, 16'h5678, 16'h9ABC, 16'h042D};
    applyStimulus();
    repeat (3) @(posedge clk_sys);
    c0 = ctrl_cnt; d0 = dec_q.size();
    pulse_fire();
    wait_idle(5000);
    checkOutput("pkt3_ctrl_len", 32'(ctrl_cnt - c0), (C == 1) ? 32'd448 : 32'd376);
    checkOutput("pkt3_nwords", 32'(dec_q.size() - d0), 32'(5 + C));
    for (int i = 0; i < 5 + C; i++) checkOutput("pkt3_word", dec_at(d0 + i), 32'(lit3[i]));

    // Random packets, with a stray fire_sync during each frame
    for (int p = 0; p < 4; p++) begin
      stim_q.delete();
      repeat ($urandom_range(1, 6)) stim_q.push_back(int'(16'($urandom)));
      mod_id = 6'($urandom);
      applyStimulus();
      repeat ($urandom_range(1, 5)) @(posedge clk_sys);
      d0 = dec_q.size();
      pulse_fire();
      repeat (30) @(posedge clk_sys);
      pulse_fire();
      wait_idle(5000);
      checkOutput("rnd_nwords", 32'(dec_q.size() - d0), 32'(m_frame_words.size()));
      foreach (m_frame_words[i]) checkOutput("rnd_word", dec_at(d0 + i), 32'(m_frame_words[i]));
    end

    // Overflow: 257 words into a 256-word buffer
    mod_id = 6'h05;
    stim_q.delete();
    for (int i = 0; i < 257; i++) stim_q.push_back(int'(16'($urandom)));
    e0 = err_cnt;
    applyStimulus();
    repeat (3) @(negedge clk_sys);
    checkOutput("ovf_err_pulses", 32'(err_cnt - e0), 32'd1);
    c0 = ctrl_cnt; d0 = dec_q.size();
    pulse_fire();
    wait_idle(40000);
    checkOutput("ovf_header", dec_at(d0 + 1), 32'h4005);
    checkOutput("ovf_nwords", 32'(dec_q.size() - d0), 32'(258 + C));
    checkOutput("ovf_ctrl_len", 32'(ctrl_cnt - c0), 32'(BD * (2 * GD + 18 * (258 + C))));

    // Second packet arriving mid-frame is dropped whole
    stim_q = '{16'h0F0F, 16'hF0F0};
    lit2 = '{16'hEB90, 16'h0085, 16'h0F0F, 16'hF0F0, 16'h0084};
    applyStimulus();
    repeat (3) @(posedge clk_sys);
    d0 = dec_q.size();
    pulse_fire();
    repeat (60) @(posedge clk_sys);
    e0 = err_cnt;
    stim_q = '{16'h0001, 16'h0002};
    applyStimulus();
    wait_idle(5000);
    checkOutput("drop_err_pulses", 32'(err_cnt - e0), 32'd1);
    checkOutput("drop_nwords", 32'(dec_q.size() - d0), 32'(4 + C));
    for (int i = 0; i < 4 + C; i++) checkOutput("drop_word", dec_at(d0 + i), 32'(lit2[i]));
    c0 = ctrl_cnt;
    pulse_fire();
    repeat (40) @(negedge clk_sys);
    checkOutput("drop_refire_ctrl", 32'(ctrl_cnt - c0), 32'd0);
    checkOutput("drop_refire_busy", 32'(busy), 32'd0);

    // Reset in the middle of the data phase, then a clean frame
    stim_q = '{16'h1111, 16'h2222, 16'h3333};
    applyStimulus();
    repeat (3) @(posedge clk_sys);
    pulse_fire();
    repeat (GB + 18 * BD * 2 + 20) @(posedge clk_sys);
    #2; rst = 1'b1;
    #1;
    checkOutput("midrst_tx_ctrl", 32'(tx_ctrl), 32'd0);
    checkOutput("midrst_tx_a", 32'(tx_a), 32'd1);
    checkOutput("midrst_tx_b", 32'(tx_b), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk_sys);
    #2; rst = 1'b0;
    mod_id = 6'h05;
    stim_q = '{16'hAAAA};
    litA = '{16'hEB90, 16'h0045, 16'hAAAA, 16'hAAEF};
    applyStimulus();
    repeat (3) @(posedge clk_sys);
    c0 = ctrl_cnt; d0 = dec_q.size();
    pulse_fire();
    wait_idle(5000);
    checkOutput("post_rst_nwords", 32'(dec_q.size() - d0), 32'(3 + C));
    for (int i = 0; i < 3 + C; i++) checkOutput("post_rst_word", dec_at(d0 + i), 32'(litA[i]));
    checkOutput("post_rst_ctrl_len", 32'(ctrl_cnt - c0), 32'(BD * (2 * GD + 18 * (3 + C))));

    repeat (5) @(negedge clk_sys);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
